ct_spsram_param_init: RTL and testbench

Parametrised single-port SRAM macro with hardware initialisation for IFU/LSU array storage. Provides:
- configurable address and data widths;
- grouped active-low bit-write enables;
- an optional output pipeline register;
- a built-in init sweep that writes a constant to every entry after reset or on request, with busy indication and dropped-access reporting.

It replaces fixed-size per-array SRAM wrappers wherever an array must come out of reset in a known state.

---
 rtl/ct_spsram_param_init.sv | 127 ++++++++++++
 tb/tb_ct_spsram_param_init.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_param_init.sv
// ct_spsram_param_init
// Single-port SRAM macro with a hardware init sweep. After reset, or on an
// init_req pulse while idle, every entry is written with INIT_VAL, one entry
// per clock. Accesses presented during the sweep are dropped and reported on
// acc_drop. Writes are masked per group by active-low WEN. Reads return data
// after one cycle, or after two cycles when OUT_REG is set.
module ct_spsram_param_init #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 44,
  parameter int                    WE_WIDTH   = 44,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  init_req,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  init_busy,
  output logic                  acc_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Bits per write-enable group; WE_WIDTH is expected to divide DATA_WIDTH.
  localparam int G     = DATA_WIDTH / WE_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] rd_p0;
  logic                  in_init;
  logic                  wr_fire;
  logic                  rd_fire;

  assign in_init   = (state == ST_INIT);
  assign init_busy = in_init;
  // Accesses are only serviced once the sweep has finished.
  assign wr_fire   = !in_init && !CEN && !GWEN;
  assign rd_fire   = !in_init && !CEN &&  GWEN;

  // Expand the active-low group enables into a per-bit write mask.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < WE_WIDTH; i++) begin
      wmask[i*G +: G] = {G{~WEN[i]}};
    end
  end

  // Sweep control: walk cnt over every entry, then idle until init_req.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= ST_INIT;
      cnt      <= '0;
      acc_drop <= 1'b0;
    end else begin
      acc_drop <= in_init && !CEN;
      case (state)
        ST_INIT: begin
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Array storage: sweep writes take priority; the array itself has no reset.
  always_ff @(posedge forever_cpuclk) begin
    if (in_init) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_fire) begin
      mem[A] <= (mem[A] & ~wmask) | (D & wmask);
    end
  end

  // Stage p0: read register, loads only on a serviced read.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_p0 <= '0;
    end else if (rd_fire) begin
      rd_p0 <= mem[A];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd_p1;

      // Stage p1: free-running output register behind the read register.
      always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          rd_p1 <= '0;
        end else begin
          rd_p1 <= rd_p0;
        end
      end

      assign Q = rd_p1;
    end else begin : g_noreg
      assign Q = rd_p0;
    end
  endgenerate

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Bench for ct_spsram_param_init: two instances share stimulus. Instance A
// uses 22 write groups, one-cycle reads and INIT_VAL=0. Instance B uses
// per-bit enables, the output register and a nonzero INIT_VAL. Stimulus pushes
// expected values tagged with the cycle they are due; a monitor compares them.
module tb_ct_spsram_param_init;

  localparam int AW    = 9;
  localparam int DW    = 44;
  localparam int DEPTH = 512;
  localparam logic [DW-1:0] INIT_A = '0;
  localparam logic [DW-1:0] INIT_B = 44'hABC_DEF0_1234;

  localparam int SQ = 0;
  localparam int SB = 1;
  localparam int SD = 2;

  typedef struct {
    int            due;
    int            dut;
    int            sig;
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t sbq[$];

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [AW-1:0] a        = '0;
  logic          cen      = 1'b1;
  logic          gwen     = 1'b1;
  logic          init_req = 1'b0;
  logic [21:0]   wen_a    = '1;
  logic [43:0]   wen_b    = '1;
  logic [DW-1:0] d        = '0;

  logic [DW-1:0] q_a, q_b;
  logic          busy_a, busy_b, drop_a, drop_b;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int n_left = 0;

  ct_spsram_param_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(22), .OUT_REG(0), .INIT_VAL(INIT_A)
  ) u_dut_a (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen_a), .D(d), .init_req(init_req), .Q(q_a), .init_busy(busy_a),
    .acc_drop(drop_a)
  );

  ct_spsram_param_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(44), .OUT_REG(1), .INIT_VAL(INIT_B)
  ) u_dut_b (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen_b), .D(d), .init_req(init_req), .Q(q_b), .init_busy(busy_b),
    .acc_drop(drop_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] actual(int dut, int sig);
    logic [DW-1:0] v;
    v = '0;
    case (sig)
      SQ:      v = (dut == 0) ? q_a : q_b;
      SB:      v = {{(DW-1){1'b0}}, (dut == 0) ? busy_a : busy_b};
      default: v = {{(DW-1){1'b0}}, (dut == 0) ? drop_a : drop_b};
    endcase
    return v;
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    logic [DW-1:0] act;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        act = actual(sbq[i].dut, sbq[i].sig);
        n_chk++;
        if (act !== sbq[i].exp)
          $display("FAIL %s dut%0d cyc=%0d got=%h want=%h",
                   sbq[i].name, sbq[i].dut, cyc, act, sbq[i].exp);
        else
          n_pass++;
        sbq.delete(i);
      end
    end
  end

  task automatic push(int due, int dut, int sig, logic [DW-1:0] exp, string name);
    exp_t e;
    e.due  = due;
    e.dut  = dut;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic push2(int due, int sig, logic [DW-1:0] ea, logic [DW-1:0] eb, string name);
    push(due, 0, sig, ea, name);
    push(due, 1, sig, eb, name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cen = 1'b1; gwen = 1'b1; init_req = 1'b0; wen_a = '1; wen_b = '1;
    step();
  endtask

  task automatic wait_until(int t);
    while (cyc < t) idle();
  endtask

  task automatic wr(logic [AW-1:0] addr, logic [DW-1:0] data,
                    logic [21:0] wa, logic [43:0] wb);
    a = addr; d = data; cen = 1'b0; gwen = 1'b0; init_req = 1'b0;
    wen_a = wa; wen_b = wb;
    step();
  endtask

  task automatic rd(logic [AW-1:0] addr, logic [DW-1:0] ea, logic [DW-1:0] eb, string name);
    a = addr; cen = 1'b0; gwen = 1'b1; init_req = 1'b0; wen_a = '1; wen_b = '1;
    push(cyc + 1, 0, SQ, ea, name);
    push(cyc + 2, 1, SQ, eb, name);
    step();
  endtask

  initial begin
    int c0, c, t3, w, r0;

    // Reset state while cpurst_b is held low.
    push2(1, SQ, '0, '0, "rst_q");
    push2(1, SB, 1, 1, "rst_busy");
    push2(1, SD, 0, 0, "rst_drop");
    step(); step();

    n_chk++;
    if (q_a !== '0 || q_b !== '0)
      $display("FAIL direct_rst_q q_a=%h q_b=%h", q_a, q_b);
    else
      n_pass++;
    n_chk++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1)
      $display("FAIL direct_rst_busy a=%b b=%b", busy_a, busy_b);
    else
      n_pass++;
    n_chk++;
    if (drop_a !== 1'b0 || drop_b !== 1'b0)
      $display("FAIL direct_rst_drop a=%b b=%b", drop_a, drop_b);
    else
      n_pass++;

    // Reset sweep: busy for exactly DEPTH cycles after release.
    rst_n = 1'b1;
    c0 = cyc;
    push2(c0, SB, 1, 1, "sweep_busy_first");
    push2(c0 + DEPTH - 1, SB, 1, 1, "sweep_busy_last");
    push2(c0 + DEPTH, SB, 0, 0, "sweep_busy_fall");
    push2(c0 + 100, SQ, '0, '0, "q_before_read");

    // Write attempted during the sweep is dropped.
    wait_until(c0 + 5);
    push2(c0 + 5, SD, 0, 0, "drop_before");
    push2(c0 + 6, SD, 1, 1, "drop_pulse");
    push2(c0 + 7, SD, 0, 0, "drop_after");
    a = 9; d = '1; cen = 1'b0; gwen = 1'b0; wen_a = '0; wen_b = '0;
    step();
    wait_until(c0 + DEPTH);

    n_chk++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0)
      $display("FAIL direct_sweep_done a=%b b=%b", busy_a, busy_b);
    else
      n_pass++;

    rd(0,   INIT_A, INIT_B, "init_a0");
    rd(511, INIT_A, INIT_B, "init_a511");
    rd(9,   INIT_A, INIT_B, "dropped_wr_entry");

    // Masked writes and a no-op write.
    wr(4, 44'hFFF_FFFF_FFFF, 22'h3FFFFE, ~44'h3);
    rd(4, 44'h000_0000_0003, 44'hABC_DEF0_1237, "masked_wr");
    wr(4, '0, '1, '1);
    rd(4, 44'h000_0000_0003, 44'hABC_DEF0_1237, "noop_wr");

    // Back-to-back reads after distinct writes.
    wr(1, 44'd11, '0, '0);
    wr(2, 44'd22, '0, '0);
    wr(3, 44'd33, '0, '0);
    rd(1, 44'd11, 44'd11, "b2b_rd1");
    rd(2, 44'd22, 44'd22, "b2b_rd2");
    t3 = cyc;
    rd(3, 44'd33, 44'd33, "b2b_rd3");
    push(t3 + 2, 0, SQ, 44'd33, "q_hold");
    push(t3 + 3, 0, SQ, 44'd33, "q_hold");
    push(t3 + 3, 1, SQ, 44'd33, "q_hold");
    push(t3 + 4, 1, SQ, 44'd33, "q_hold");
    idle(); idle(); idle();

    // A write leaves Q untouched.
    w = cyc;
    push2(w + 1, SQ, 44'd33, 44'd33, "no_write_through");
    push2(w + 2, SQ, 44'd33, 44'd33, "no_write_through");
    wr(3, 44'd99, '0, '0);
    idle();
    rd(3, 44'd99, 44'd99, "rd_after_wr");
    wr(5, 44'd55, '0, '0);
    rd(5, 44'd55, 44'd55, "wr_then_rd");
    idle(); idle();

    // init_req together with a write; later init_req and accesses ignored.
    c = cyc;
    push2(c, SB, 0, 0, "req_busy_before");
    push2(c + 1, SB, 1, 1, "req_busy_start");
    push2(c + DEPTH, SB, 1, 1, "req_busy_last");
    push2(c + DEPTH + 1, SB, 0, 0, "req_busy_fall");
    push2(c + 150, SD, 0, 0, "no_drop_cen_high");
    push2(c + 201, SD, 1, 1, "drop_run1");
    push2(c + 202, SD, 1, 1, "drop_run2");
    push2(c + 203, SD, 0, 0, "drop_run_end");
    push2(c + 202, SQ, 44'd55, 44'd55, "q_hold_on_drop");
    a = 7; d = 44'd5; cen = 1'b0; gwen = 1'b0; wen_a = '0; wen_b = '0; init_req = 1'b1;
    step();
    wait_until(c + 100);
    cen = 1'b1; init_req = 1'b1;
    step();
    wait_until(c + 200);
    a = 5; cen = 1'b0; gwen = 1'b1; init_req = 1'b0;
    step(); step();
    wait_until(c + DEPTH + 1);
    rd(7, INIT_A, INIT_B, "req_wr_swept");
    rd(5, INIT_A, INIT_B, "req_entry5_swept");

    // Reset in the middle of a sweep.
    wr(3, 44'd77, '0, '0);
    rd(3, 44'd77, 44'd77, "pre_rst_rd");
    idle(); idle();
    c = cyc;
    push2(c + 1, SB, 1, 1, "req2_busy");
    push2(c + 199, SQ, 44'd77, 44'd77, "q_hold_in_init");
    cen = 1'b1; init_req = 1'b1;
    step();
    wait_until(c + 200);
    rst_n = 1'b0;
    push2(cyc, SQ, '0, '0, "midrst_q");
    push2(cyc, SB, 1, 1, "midrst_busy");
    #1;
    n_chk++;
    if (q_a !== '0 || q_b !== '0)
      $display("FAIL direct_midrst_q q_a=%h q_b=%h", q_a, q_b);
    else
      n_pass++;
    n_chk++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1)
      $display("FAIL direct_midrst_busy a=%b b=%b", busy_a, busy_b);
    else
      n_pass++;
    step(); step();
    rst_n = 1'b1;
    r0 = cyc;
    push2(r0 + DEPTH - 1, SB, 1, 1, "rerst_busy_last");
    push2(r0 + DEPTH, SB, 0, 0, "rerst_busy_fall");
    push2(r0 + 10, SQ, '0, '0, "rerst_q");
    wait_until(r0 + DEPTH);
    rd(3, INIT_A, INIT_B, "rerst_rd");
    idle(); idle(); idle(); idle();

    // Anything still queued was never compared.
    foreach (sbq[i]) begin
      $display("FAIL %s dut%0d never checked (due cyc=%0d, now %0d)",
               sbq[i].name, sbq[i].dut, sbq[i].due, cyc);
      n_left++;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk + n_left);
    $finish;
  end

endmodule
